// File: rtl/spi_loader_pkg.sv
// Shared types and default sizing for the SPI word loader and its clock divider.
package spi_loader_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_GRST_CYCLES = 8;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the gated serial clock: idles low while disabled and
// flags, one cycle ahead, the SCLK edge on which the output rises or falls.
module spi_clk_div
  import spi_loader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_clk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int             CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Strobes are combinational so the owner acts on the same edge that toggles o_clk.
  assign o_clk      = r_clk;
  assign o_rise_stb = w_wrap & ~r_clk;
  assign o_fall_stb = w_wrap &  r_clk;

endmodule

// File: rtl/spi_word_loader.sv
// Host-side serializer for a DATA_W-bit serial-to-parallel target: shifts a word out
// MSB first on a gated clock and captures SOUT. Optional macro: SPI_LOOPBACK_CHECK_EN.
module spi_word_loader
  import spi_loader_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int GRST_CYCLES = DEF_GRST_CYCLES
) (
  input  logic              i_sclk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_regsel,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  output logic              o_sin,
  output logic              o_clk,
  output logic              o_regsel,
  output logic              o_grst,
  input  logic              i_sout,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy
`ifdef SPI_LOOPBACK_CHECK_EN
  ,
  output logic              o_mismatch
`endif
);

  localparam int            BW        = cnt_w(DATA_W);
  localparam int            GW        = cnt_w(GRST_CYCLES);
  localparam logic [GW-1:0] GRST_LAST = GW'(GRST_CYCLES - 1);
  localparam logic [BW-1:0] BIT_MSB   = BW'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [GW-1:0]     r_init_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_sin;
  logic              r_regsel;
  logic              r_grst;
  logic              r_rd_valid;
  logic              w_accept;
  logic              w_shift_en;
  logic              w_init_done;
  logic              w_rise;
  logic              w_fall;
  logic              w_last_fall;

  assign w_accept    = o_wr_ready & i_wr_valid;
  assign w_shift_en  = (r_state == ST_SHIFT);
  assign w_init_done = (r_init_cnt == GRST_LAST);
  assign w_last_fall = w_fall && (r_bit_cnt == '0);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk      (i_sclk),
    .i_rst_n    (i_rst_n),
    .i_en       (w_shift_en),
    .o_clk      (o_clk),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_wr_ready   = 1'b0;
    o_busy       = 1'b1;
    unique case (r_state)
      ST_INIT:  if (w_init_done) w_state_next = ST_IDLE;
      ST_IDLE: begin
        o_wr_ready = 1'b1;
        o_busy     = 1'b0;
        if (i_wr_valid) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: if (w_last_fall) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_INIT;
    endcase
  end

  // GRST rises together with the INIT->IDLE transition and stays high until reset.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_cnt <= '0;
      r_grst     <= 1'b0;
    end else if (r_state == ST_INIT) begin
      if (w_init_done) begin
        r_grst <= 1'b1;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // The MSB goes out on the accept edge; later bits change only on clk falls,
  // and the final fall leaves the last bit on SIN.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx      <= '0;
      r_sin     <= 1'b0;
      r_regsel  <= 1'b0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_tx      <= i_wr_data;
      r_sin     <= i_wr_data[DATA_W-1];
      r_regsel  <= i_wr_regsel;
      r_bit_cnt <= BIT_MSB;
    end else if (w_fall && !w_last_fall) begin
      r_tx      <= r_tx << 1;
      r_sin     <= r_tx[DATA_W-2];
      r_bit_cnt <= r_bit_cnt - 1'b1;
    end
  end

  // SOUT is taken on the edge that raises clk, before the target shifts.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx <= '0;
    end else if (w_accept) begin
      r_rx <= '0;
    end else if (w_rise) begin
      r_rx <= {r_rx[DATA_W-2:0], i_sout};
    end
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_last_fall;
      if (w_last_fall) r_rd_data <= r_rx;
    end
  end

`ifdef SPI_LOOPBACK_CHECK_EN
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_expected;
  logic              r_mismatch;

  // The target returns what it held before this frame, i.e. the previous word.
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word     <= '0;
      r_expected <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (r_state == ST_INIT) begin
        r_expected <= '0;
      end else if (w_accept) begin
        r_word <= i_wr_data;
      end else if (w_last_fall) begin
        r_mismatch <= (r_rx != r_expected);
        r_expected <= r_word;
      end
    end
  end

  assign o_mismatch = r_mismatch;
`endif

  assign o_sin      = r_sin;
  assign o_regsel   = r_regsel;
  assign o_grst     = r_grst;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_spi_word_loader.sv
// Bench for spi_word_loader: two instances (CLK_DIV 4 and 1), each talking to a
// behavioural 32-bit target shift register; readback expected = previous word written.
module tb_spi_word_loader;

  localparam int W = 32;
  localparam int G = 8;

  logic              sclk = 1'b0;
  logic              rst_n;
  logic [1:0][W-1:0] wr_data;
  logic [1:0]        wr_regsel;
  logic [1:0]        wr_valid;
  logic [1:0]        wr_ready;
  logic [1:0]        sin;
  logic [1:0]        tclk;
  logic [1:0]        regsel;
  logic [1:0]        grst;
  logic [1:0]        sout;
  logic [1:0][W-1:0] rd_data;
  logic [1:0]        rd_valid;
  logic [1:0]        busy;
  logic [1:0]        flip;
`ifdef SPI_LOOPBACK_CHECK_EN
  logic [1:0]        mism;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last [2];

  always #5 sclk = ~sclk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [W-1:0] r_tgt;

      spi_word_loader #(
        .DATA_W      (W),
        .CLK_DIV     (gi == 0 ? 4 : 1),
        .GRST_CYCLES (G)
      ) u_dut (
        .i_sclk      (sclk),
        .i_rst_n     (rst_n),
        .i_wr_data   (wr_data[gi]),
        .i_wr_regsel (wr_regsel[gi]),
        .i_wr_valid  (wr_valid[gi]),
        .o_wr_ready  (wr_ready[gi]),
        .o_sin       (sin[gi]),
        .o_clk       (tclk[gi]),
        .o_regsel    (regsel[gi]),
        .o_grst      (grst[gi]),
        .i_sout      (sout[gi]),
        .o_rd_data   (rd_data[gi]),
        .o_rd_valid  (rd_valid[gi]),
        .o_busy      (busy[gi])
`ifdef SPI_LOOPBACK_CHECK_EN
        ,
        .o_mismatch  (mism[gi])
`endif
      );

      // Target: shifts SIN in on its clock rise, SOUT is its MSB, cleared while GRST low.
      always @(posedge tclk[gi] or negedge grst[gi]) begin
        if (!grst[gi]) r_tgt <= '0;
        else           r_tgt <= {r_tgt[W-2:0], sin[gi]};
      end
      assign sout[gi] = r_tgt[W-1] ^ flip[gi];
    end
  endgenerate

  function automatic int lat_of(input int i);
    return 1 + 2 * (i == 0 ? 4 : 1) * W;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (wr_ready[i] !== 1'b1 && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    chk("ready_timeout", 32'(wr_ready[i]), 32'd1);
  endtask

  // One frame with SIN/REGSEL checked every cycle against the word's bit order.
  task automatic frame(input int i, input logic [W-1:0] w, input logic rs,
                       input logic [W-1:0] exp_rd, input logic exp_mis, input bit pulse);
    int   cyc, rises, bad_sin, bad_rs, b;
    logic pclk;
    wait_ready(i);
    wr_data[i]   = w;
    wr_regsel[i] = rs;
    wr_valid[i]  = 1'b1;
    @(negedge sclk);
    wr_valid[i]  = 1'b0;
    wr_data[i]   = $urandom;
    wr_regsel[i] = ~rs;
    chk("busy_c1", 32'(busy[i]), 32'd1);
    cyc = 1; rises = 0; bad_sin = 0; bad_rs = 0; pclk = 1'b0;
    while (rd_valid[i] !== 1'b1 && cyc < 400) begin
      if (tclk[i] === 1'b1 && pclk === 1'b0) rises++;
      b = (tclk[i] === 1'b1) ? rises - 1 : rises;
      if (b > W - 1) b = W - 1;
      if (b < 0) b = 0;
      if (sin[i] !== w[W-1-b]) bad_sin++;
      if (regsel[i] !== rs) bad_rs++;
      if (pulse && cyc == 40) begin
        wr_valid[i] = 1'b1;
        wr_data[i]  = '1;
      end else if (pulse && cyc == 41) begin
        wr_valid[i] = 1'b0;
      end
      pclk = tclk[i];
      @(negedge sclk);
      cyc++;
    end
    chk("latency", cyc, lat_of(i));
    chk("clk_rises", rises, W);
    chk("sin_bits", bad_sin, 0);
    chk("regsel_hold", bad_rs, 0);
    chk("rd_data", rd_data[i], exp_rd);
    chk("clk_low_done", 32'(tclk[i]), 32'd0);
    chk("ready_in_done", 32'(wr_ready[i]), 32'd0);
`ifdef SPI_LOOPBACK_CHECK_EN
    chk("mismatch", 32'(mism[i]), 32'(exp_mis));
`endif
    $display("frame inst=%0d wr=0x%08h rs=%0b rd=0x%08h want=0x%08h lat=%0d chk_mis=%0b",
             i, w, rs, rd_data[i], exp_rd, cyc, exp_mis);
    @(negedge sclk);
    chk("rd_valid_1cyc", 32'(rd_valid[i]), 32'd0);
    chk("ready_after", 32'(wr_ready[i]), 32'd1);
    chk("regsel_after", 32'(regsel[i]), 32'(rs));
    chk("sin_hold", 32'(sin[i]), 32'(w[0]));
  endtask

  typedef struct {
    int           inst;
    logic [W-1:0] data;
    logic         rs;
    bit           flp;
    bit           pulse;
    logic [W-1:0] exp_rd;
    logic         exp_mis;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc, rises, rv, first;
    logic         pclk;
    logic [W-1:0] w, b1, b2;

    vecs[0] = '{0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[2] = '{0, 32'hA5A5_0F0F, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
    vecs[5] = '{1, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1};

    rst_n = 1'b0; wr_data = '0; wr_regsel = '0; wr_valid = '0; flip = '0;
    last[0] = '0; last[1] = '0;
    repeat (3) @(negedge sclk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(wr_ready[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd1);
      chk("rst_grst", 32'(grst[i]), 32'd0);
      chk("rst_clk", 32'(tclk[i]), 32'd0);
      chk("rst_sin", 32'(sin[i]), 32'd0);
      chk("rst_regsel", 32'(regsel[i]), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid[i]), 32'd0);
      chk("rst_rd_data", rd_data[i], 32'd0);
    end

    rst_n = 1'b1;
    for (int k = 1; k <= G; k++) begin
      @(negedge sclk);
      for (int i = 0; i < 2; i++) begin
        chk("init_grst", 32'(grst[i]), 32'(k == G));
        chk("init_ready", 32'(wr_ready[i]), 32'(k == G));
        chk("init_clk", 32'(tclk[i]), 32'd0);
      end
    end

    for (int v = 0; v < 6; v++) begin
      flip[vecs[v].inst] = vecs[v].flp;
      frame(vecs[v].inst, vecs[v].data, vecs[v].rs, vecs[v].exp_rd, vecs[v].exp_mis, vecs[v].pulse);
      flip = '0;
      last[vecs[v].inst] = vecs[v].data;
    end

    // Back-to-back on the CLK_DIV=1 instance with WR_VALID held high.
    b1 = 32'hCAFE_F00D;
    b2 = 32'h0BAD_CAFE;
    wait_ready(1);
    wr_data[1] = b1; wr_regsel[1] = 1'b0; wr_valid[1] = 1'b1;
    @(negedge sclk);
    wr_data[1] = b2; wr_regsel[1] = 1'b1;
    cyc = 1;
    while (rd_valid[1] !== 1'b1 && cyc < 200) begin @(negedge sclk); cyc++; end
    chk("b2b_lat1", cyc, lat_of(1));
    chk("b2b_rd1", rd_data[1], last[1]);
    @(negedge sclk);
    chk("b2b_ready", 32'(wr_ready[1]), 32'd1);
    @(negedge sclk);
    chk("b2b_busy", 32'(busy[1]), 32'd1);
    chk("b2b_sin_msb", 32'(sin[1]), 32'(b2[W-1]));
    chk("b2b_regsel", 32'(regsel[1]), 32'd1);
    wr_valid[1] = 1'b0;
    cyc = 1;
    while (rd_valid[1] !== 1'b1 && cyc < 200) begin @(negedge sclk); cyc++; end
    chk("b2b_lat2", cyc, lat_of(1));
    chk("b2b_rd2", rd_data[1], b1);
    $display("b2b inst=1 w1=0x%08h w2=0x%08h rd2=0x%08h", b1, b2, rd_data[1]);
    last[1] = b2;

    for (int n = 0; n < 6; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      w = $urandom;
      frame(i, w, 1'($urandom_range(0, 1)), last[i], 1'b0, 1'($urandom_range(0, 1)));
      last[i] = w;
    end

    // Reset during bit 10 of a frame, while clk is high.
    wait_ready(0);
    wr_data[0] = $urandom; wr_valid[0] = 1'b1;
    @(negedge sclk);
    wr_valid[0] = 1'b0;
    rises = 0; pclk = 1'b0; cyc = 0;
    while (rises < 11 && cyc < 400) begin
      @(negedge sclk);
      cyc++;
      if (tclk[0] === 1'b1 && pclk === 1'b0) rises++;
      pclk = tclk[0];
    end
    chk("rst_mid_reached", rises, 11);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_clk", 32'(tclk[0]), 32'd0);
    chk("rst_async_grst", 32'(grst[0]), 32'd0);
    chk("rst_async_rdv", 32'(rd_valid[0]), 32'd0);
    chk("rst_async_busy", 32'(busy[0]), 32'd1);
    @(negedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    rv = 0; first = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge sclk);
      if (rd_valid[0] === 1'b1) rv++;
      if (grst[0] === 1'b1 && first == 0) first = k;
    end
    chk("no_rdv_after_rst", rv, 0);
    chk("init_repeat", first, G);
    $display("reset mid-frame: rd_valid pulses=%0d grst_high_after=%0d", rv, first);
    last[0] = '0;
    last[1] = '0;
    frame(0, 32'h5A5A_1234, 1'b1, last[0], 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_word_loader.md
Name: spi_word_loader

Overview:
- Host-side serializer that sits directly upstream of the 32-bit serial-to-parallel target.
- Accepts parallel words over a valid/ready handshake and drives the target's SIN, gated serial clock `clk`, REGSEL and GRST.
- Captures the target's SOUT readback into a parallel word.
- Replaces fixed-pattern stimulus generation with host-programmable frames.

Parameters:
- DATA_W, 32: frame length in bits; equals the target shift-register width.
- CLK_DIV, 4: SCLK cycles per half-period of `clk`; legal range ≥1.
- GRST_CYCLES, 8: SCLK cycles GRST is held low after reset; legal range ≥1.

Ports:
- SCLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, asynchronous, active-low.
- WR_DATA  in  DATA_W  word to shift out, MSB first.
- WR_REGSEL  in  1  REGSEL value for this frame.
- WR_VALID  in  1  host offers WR_DATA/WR_REGSEL.
- WR_READY  out  1  loader can accept a word.
- SIN  out  1  serial data to target.
- clk  out  1  gated serial clock to target; idles low.
- REGSEL  out  1  register select to target.
- GRST  out  1  target reset, active-low (target RESET = ~GRST).
- SOUT  in  1  serial readback from target.
- RD_DATA  out  DATA_W  captured readback word.
- RD_VALID  out  1  one-cycle strobe; RD_DATA is valid.
- BUSY  out  1  high from INIT through DONE, i.e. whenever not IDLE.

Behaviour:
- Reset values: WR_READY=0, SIN=0, clk=0, REGSEL=0, GRST=0, RD_DATA=0, RD_VALID=0, BUSY=1. State=INIT.
- FSM states and transitions:
  - INIT: counts GRST_CYCLES with GRST=0. Next state is IDLE, and GRST=1 from that cycle on.
  - IDLE: WR_READY=1, BUSY=0. On WR_VALID&WR_READY (cycle 0), latch WR_DATA into the tx shift register and WR_REGSEL into REGSEL, then go to SHIFT.
  - SHIFT: bit counter runs DATA_W-1..0. For each bit, `clk` is low for CLK_DIV cycles then high for CLK_DIV cycles.
    - SIN updates only while `clk` is low: at the first low cycle of each bit.
    - SOUT is sampled into the rx shift register (shift in at LSB) on the cycle `clk` goes high.
  - DONE (one cycle): RD_DATA <= rx register, RD_VALID=1, clk=0, then IDLE.
- Latency:
  - First SIN bit (MSB) valid at cycle 1.
  - First `clk` rise at cycle 1+CLK_DIV.
  - Last `clk` fall at cycle 1+2*CLK_DIV*DATA_W.
  - RD_VALID at that same cycle, 1+2*CLK_DIV*DATA_W.
- Throughput: WR_READY rises the cycle after DONE. A word presented then is accepted immediately, with no extra gap cycle.
- Hold rules:
  - REGSEL holds its latched value until the next acceptance.
  - SIN holds its last bit after the frame.
- Handshake:
  - WR_VALID while WR_READY=0 is ignored; nothing is queued.
  - WR_DATA is sampled only on the accept cycle.
- Reset mid-frame: all state clears asynchronously. clk=0 and GRST=0 immediately, the partial frame is discarded, no RD_VALID is issued, and the FSM restarts in INIT.
- CLK_DIV=1: clk toggles every SCLK cycle; a frame is 2*DATA_W cycles.
- The rx register clears at accept, so RD_DATA depends only on the current frame.

Optional Feature:
- Macro: SPI_LOOPBACK_CHECK_EN.
- With the macro defined:
  - Add output MISMATCH (1 bit) and an internal DATA_W-bit expected register, initialised to 0 on reset and on INIT.
  - MISMATCH pulses with RD_VALID when RD_DATA ≠ expected, since the target shifts out its previous contents.
  - Expected <= word latched at that frame's accept.
- Without the macro: no MISMATCH port and no expected register.

Decomposition:
- Package spi_loader_pkg: state enum (INIT, IDLE, SHIFT, DONE), default DATA_W/CLK_DIV/GRST_CYCLES constants.
- Sub-module spi_clk_div: half-period counter with enable.
  - Outputs `clk` level plus one-cycle rise_stb/fall_stb.
  - Count resets when enable is low.

Test Plan:
- Reset release, GRST_CYCLES=8: GRST=0 for 8 cycles then 1; WR_READY=1 on the same cycle; clk stays 0 throughout.
- CLK_DIV=4, WR_DATA=0xA5A5_0F0F, WR_REGSEL=1:
  - SIN reproduces bit pattern MSB first, each bit stable across its clk rise.
  - REGSEL=1 throughout.
  - RD_VALID at cycle 257.
- SOUT driven by a bench model of a 32-bit shift register, initialised to 0:
  - Write 0x1234_5678 → RD_DATA=0x0000_0000.
  - Then write 0xDEAD_BEEF → RD_DATA=0x1234_5678.
  - With SPI_LOOPBACK_CHECK_EN, MISMATCH=0 both times; corrupt one model bit → MISMATCH=1.
- Back-to-back, CLK_DIV=1:
  - Hold WR_VALID high with two words → second accepted the cycle after the first RD_VALID.
  - Frames 64 cycles each.
- WR_VALID pulsed mid-frame with 0xFFFF_FFFF → ignored; the in-flight frame's SIN is unchanged.
- Assert RST at bit 10 of a frame → clk, GRST, RD_VALID go 0 asynchronously; no RD_VALID after release; INIT repeats.
